// File: rtl/fp_norm_if.sv
// fp_norm_if: handshake bundle for the floating-point normalizer.
//
// Valid/ready semantics: a transfer happens on a rising clock edge on which
// both valid and ready are high. A source that raises valid keeps valid and
// its payload unchanged until that transfer edge. A sink may raise or drop
// ready at any time.
//   in_*  : upstream -> normalizer (in_ready is driven by the normalizer)
//   out_* : normalizer -> downstream (out_ready is driven by downstream)
//
// Modports:
//   master - the environment: drives inputs and out_ready
//   slave  - the normalizer: drives in_ready and the result signals
interface fp_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic [24:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;

    modport master (
        output in_valid, in_sign, in_ex, in_man, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_ex, in_man, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: normalizes an unnormalized single-precision mantissa sum
// into an IEEE-754 single, with overflow to infinity and flush-to-zero on
// underflow. Truncation only, no rounding.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - fp_norm_if.slave (input offer, result handshake, flags)
//   dbg_state - current FSM state (0 IDLE, 1 CHECK, 2 SHIFT, 3 DONE)
module fp_normalizer (
    input  logic       clk,
    input  logic       rst_n,
    fp_norm_if.slave   bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ex_q, ex_d;
    logic [24:0] man_q, man_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [7:0]  ex_inc, ex_dec;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            ex_q     <= 8'h00;
            man_q    <= 25'h0;
            result_q <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ex_q     <= ex_d;
            man_q    <= man_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        ex_d     = ex_q;
        man_d    = man_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ex_inc   = ex_q + 8'd1;
        ex_dec   = ex_q - 8'd1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    ex_d    = bus.in_ex;
                    man_d   = bus.in_man;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (man_q == 25'h0) begin
                    result_d = {sign_q, 31'h0};
                end else if (man_q[24]) begin
                    man_d = {1'b0, man_q[24:1]};
                    // ex >= FE: the increment reaches (or would wrap past) FF
                    if (ex_q >= 8'hFE) begin
                        ex_d     = 8'hFF;
                        result_d = {sign_q, 8'hFF, 23'h0};
                        ovf_d    = 1'b1;
                    end else begin
                        ex_d     = ex_inc;
                        result_d = {sign_q, ex_inc, man_q[23:1]};
                    end
                end else if (man_q[23]) begin
                    result_d = {sign_q, ex_q, man_q[22:0]};
                end else if (ex_q == 8'h00) begin
                    result_d = {sign_q, 31'h0};
                    unf_d    = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (man_q[23]) begin
                    result_d = {sign_q, ex_q, man_q[22:0]};
                    state_d  = DONE;
                end else if (ex_q <= 8'd1) begin
                    result_d = {sign_q, 31'h0};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    man_d = {man_q[23:0], 1'b0};
                    ex_d  = ex_dec;
                    // The shift that brings the leading one into bit 23 also
                    // produces the result, so k shifts take exactly k cycles.
                    if (man_q[22]) begin
                        result_d = {sign_q, ex_dec, man_q[21:0], 1'b0};
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.out_result = result_q;
        bus.out_ovf    = ovf_q;
        bus.out_unf    = unf_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;

    fp_norm_if bus ();

    fp_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic [24:0] man;
        logic [31:0] exp_result;
        logic        exp_ovf;
        logic        exp_unf;
        int          exp_lat;   // edges after the accept edge until out_valid
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("wait_in_ready", {31'b0, bus.in_ready}, 32'h1);
    endtask

    // Offer one input and return the edge count until out_valid.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, output int lat);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_ex    = e;
        bus.in_man   = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_ex    = 8'h00;
        bus.in_man   = 25'h0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_ex     = 8'h00;
        bus.in_man    = 25'h0;
        bus.out_ready = 1'b0;

        //           sign  ex     man            result        ovf   unf   lat
        vecs[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 1};
        vecs[3]  = '{1'b0, 8'h80, 25'h0200000, 32'h3F000000, 1'b0, 1'b0, 3};
        vecs[4]  = '{1'b1, 8'h55, 25'h0000000, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b0, 8'h02, 25'h0000001, 32'h00000000, 1'b0, 1'b1, 3};
        vecs[6]  = '{1'b1, 8'h81, 25'h0C00000, 32'hC0C00000, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 8'h80, 25'h1800001, 32'h40C00000, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b1, 8'h00, 25'h0400000, 32'h80000000, 1'b0, 1'b1, 1};
        vecs[9]  = '{1'b0, 8'h01, 25'h0400000, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[10] = '{1'b0, 8'h02, 25'h0400000, 32'h00800000, 1'b0, 1'b0, 2};
        vecs[11] = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 24};
        vecs[12] = '{1'b0, 8'hFD, 25'h1000002, 32'h7F000001, 1'b0, 1'b0, 1};

        rst_n = 1'b0;
        #12;
        check("rst_result",   bus.out_result, 32'h0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        check("rst_flags",    {30'b0, bus.out_ovf, bus.out_unf}, 32'h0);
        check("rst_state",    {30'b0, dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].sign, vecs[i].ex, vecs[i].man, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_result", i), bus.out_result, vecs[i].exp_result);
            check($sformatf("v%0d_ovf", i), {31'b0, bus.out_ovf}, {31'b0, vecs[i].exp_ovf});
            check($sformatf("v%0d_unf", i), {31'b0, bus.out_unf}, {31'b0, vecs[i].exp_unf});
            consume();
            check($sformatf("v%0d_back_idle", i), {31'b0, bus.in_ready}, 32'h1);
        end

        // Back-pressure in DONE with a competing input offer
        send(1'b0, 8'h7F, 25'h0800000, lat);
        check("stall_latency", lat, 1);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_ex    = 8'h10;
        bus.in_man   = 25'h0800000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_result", c), bus.out_result, 32'h3F800000);
            check($sformatf("stall%0d_valid", c), {31'b0, bus.out_valid}, 32'h1);
            check($sformatf("stall%0d_in_ready", c), {31'b0, bus.in_ready}, 32'h0);
        end
        consume();
        check("handoff_idle", {30'b0, dbg_state}, 32'h0);
        check("handoff_valid", {31'b0, bus.out_valid}, 32'h0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("handoff_no_capture", {30'b0, dbg_state}, 32'h0);

        // Reset during SHIFT aborts the operation
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_ex    = 8'h7F;
        bus.in_man   = 25'h0000001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_shift", {30'b0, dbg_state}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("abort_result",   bus.out_result, 32'h0);
        check("abort_flags",    {30'b0, bus.out_ovf, bus.out_unf}, 32'h0);
        check("abort_valid",    {31'b0, bus.out_valid}, 32'h0);
        check("abort_in_ready", {31'b0, bus.in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) lat++;
        end
        check("abort_no_valid_after", lat, 0);

        // Normal operation resumes after the abort
        send(1'b0, 8'h7F, 25'h1000000, lat);
        check("resume_result", bus.out_result, 32'h40000000);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream offers an unnormalized sum.
REQ-005 in_ready  output  1  block accepts an input; high only in IDLE.
REQ-006 in_sign  input  1  sign of the sum.
REQ-007 in_ex  input  8  unsigned biased exponent of the sum, from the alignment stage (the larger operand exponent).
REQ-008 in_man  input  25  unsigned mantissa sum: [24] carry-out, [23] hidden-bit position, [22:0] fraction.
REQ-009 out_valid  output  1  out_result and flags are valid.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_result  output  32  IEEE-754 single: {sign, exponent[7:0], fraction[22:0]}.
REQ-012 out_ovf  output  1  exponent overflow occurred; result is signed infinity.
REQ-013 out_unf  output  1  exponent underflow occurred; result is flushed to signed zero.

Function
REQ-014 SHALL implement an FSM with states IDLE, CHECK, SHIFT, DONE; registers sign_r, ex_r[7:0], man_r[24:0].
REQ-015 IDLE: in_valid=1 loads in_sign/in_ex/in_man into the registers, clears out_ovf/out_unf, and moves to CHECK; in_valid=0 holds IDLE.
REQ-016 CHECK, man_r==0: result {sign_r, 8'h00, 23'h0}, no flags, go to DONE.
REQ-017 CHECK, man_r[24]=1: man_r>>1, ex_r+1; if ex_r+1==8'hFF, result {sign_r, 8'hFF, 23'h0} with out_ovf=1; go to DONE.
REQ-018 CHECK, man_r[24:23]==2'b01: go to DONE; result {sign_r, ex_r, man_r[22:0]}.
REQ-019 CHECK, man_r[24:23]==2'b00: if ex_r==0, flush to signed zero with out_unf=1 and go to DONE; else go to SHIFT.
REQ-020 SHIFT, each cycle: man_r[23]=1 -> DONE; else ex_r==1 -> flush to signed zero, out_unf=1, DONE; else man_r<<1, ex_r-1, stay in SHIFT.
REQ-021 Arithmetic SHALL be unsigned 8-bit on the exponent, truncation only (no rounding), with no wrap: overflow and underflow are caught by REQ-017, REQ-019 and REQ-020.
REQ-022 Latency SHALL be: input accepted at edge T, out_valid high from T+2 for normalized, carry, zero and overflow inputs, and from T+2+k when k left shifts are required (k<=23).
REQ-023 DONE: out_valid=1; out_result and the flags SHALL stay stable until out_ready=1, then return to IDLE on that edge.
REQ-024 The input SHALL be ignored outside IDLE; there is no accept in the same cycle as the DONE->IDLE handoff.
REQ-025 out_result, out_ovf and out_unf SHALL be registered; out_valid = (state==DONE); in_ready = (state==IDLE).

Reset
REQ-026 rst_n=0 SHALL force IDLE immediately, with out_result=0, out_ovf=0, out_unf=0, out_valid=0, in_ready=1, and all internal registers at 0.
REQ-027 Reset asserted in CHECK, SHIFT or DONE SHALL abort the operation; no out_valid pulse follows the release of reset.

Verification
REQ-028 in_ex=8'h7F, in_man=25'h0800000, sign 0 -> out_result=32'h3F800000 at T+2, no flags.
REQ-029 in_ex=8'h7F, in_man=25'h1000000 -> 32'h40000000 at T+2; in_ex=8'hFE, in_man=25'h1000000 -> 32'h7F800000 with out_ovf=1.
REQ-030 in_ex=8'h80, in_man=25'h0200000 -> 32'h3F000000 at T+4 (two shifts).
REQ-031 sign 1, in_man=0 -> 32'h80000000 at T+2; in_ex=8'h02, in_man=25'h0000001 -> 32'h00000000 with out_unf=1.
REQ-032 out_ready held low 5 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-033 rst_n pulsed low during SHIFT -> outputs zero at once, in_ready=1, no out_valid after release.
